// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: ASCII constants, parser states and response sizing shared by the UART command parser.
package uart_cmd_pkg;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CH_W  = "W";
    localparam logic [7:0] CH_R  = "R";
    localparam logic [7:0] CH_O  = "O";
    localparam logic [7:0] CH_K  = "K";
    localparam logic [7:0] CH_E  = "E";
    localparam int RESP_LEN = 4;
    localparam int RESP_IW  = $clog2(RESP_LEN);

    typedef enum logic [2:0] {IDLE, ARGS, EXEC, READ_WAIT, DISCARD, RESP} state_t;

    // Case-insensitive match of a received byte against an uppercase letter.
    function automatic logic is_letter(input logic [7:0] b, input logic [7:0] up);
        return (b | 8'h20) == (up | 8'h20);
    endfunction
endpackage

// File: rtl/hex_ascii_conv.sv
// hex_ascii_conv: ASCII hex digit decode and byte-to-uppercase-hex encode.
module hex_ascii_conv (
    input  logic [7:0] ascii,
    input  logic [7:0] value,
    output logic       is_hex,
    output logic [3:0] nibble,
    output logic [7:0] hex_hi,
    output logic [7:0] hex_lo
);
    logic       dig;
    logic       alpha;
    logic [7:0] low;

    // Folding bit 5 maps 'A'-'F' onto 'a'-'f'; digits are tested unfolded.
    assign low    = ascii | 8'h20;
    assign dig    = ascii >= "0" && ascii <= "9";
    assign alpha  = low >= "a" && low <= "f";
    assign is_hex = dig || alpha;
    assign nibble = dig ? ascii[3:0] : ascii[3:0] + 4'd9;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return n < 4'd10 ? {4'h3, n} : {4'h0, n} + 8'h37;
    endfunction

    assign hex_hi = to_ascii(value[7:4]);
    assign hex_lo = to_ascii(value[3:0]);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: line console turning "W aa dd" / "R aa" into register-bus accesses with ASCII replies.
// Define UART_CMD_ECHO_EN to echo every accepted byte ahead of the response.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LINE     = 8,
    parameter int TERM_LF_ONLY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_ready,
    input  logic       uart_tx_fifo_ready,
    output logic       start_uart_tx,
    output logic [7:0] uart_tx_data,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       rx_overrun
);
    localparam int LW = $clog2(MAX_LINE + 5);

    state_t                state;
    logic                  op_write;
    logic [15:0]           acc;
    logic [LW-1:0]         nib_cnt;
    logic [LW-1:0]         line_len;
    logic [8*RESP_LEN-1:0] resp;
    logic [RESP_IW-1:0]    resp_idx;
    logic                  is_hex;
    logic [3:0]            nibble;
    logic [7:0]            hex_hi;
    logic [7:0]            hex_lo;
    logic                  is_term;
    logic                  is_space;
    logic                  tx_slot;
    logic                  resp_slot;
    logic                  accepting;

    hex_ascii_conv u_conv (
        .ascii (uart_rx_data),
        .value (reg_rdata),
        .is_hex(is_hex),
        .nibble(nibble),
        .hex_hi(hex_hi),
        .hex_lo(hex_lo)
    );

    assign is_term   = uart_rx_data == LF || (TERM_LF_ONLY == 0 && uart_rx_data == CR);
    assign is_space  = uart_rx_data == SPACE;
    // The FIFO ready flag lags an enqueue by a cycle, so never strobe twice in a row.
    assign tx_slot   = uart_tx_fifo_ready && !start_uart_tx;
    assign accepting = state == IDLE || state == ARGS || state == DISCARD;

`ifdef UART_CMD_ECHO_EN
    logic       echo_full;
    logic [7:0] echo_byte;
    assign resp_slot = tx_slot && !echo_full;
`else
    assign resp_slot = tx_slot;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_write      <= 1'b0;
            acc           <= '0;
            nib_cnt       <= '0;
            line_len      <= '0;
            resp          <= '0;
            resp_idx      <= '0;
            start_uart_tx <= 1'b0;
            uart_tx_data  <= '0;
            reg_addr      <= '0;
            reg_wdata     <= '0;
            reg_we        <= 1'b0;
            reg_re        <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_CMD_ECHO_EN
            echo_full     <= 1'b0;
            echo_byte     <= '0;
`endif
        end else begin
            start_uart_tx <= 1'b0;
            reg_we        <= 1'b0;
            reg_re        <= 1'b0;
            if (uart_rx_ready && !accepting) rx_overrun <= 1'b1;
`ifdef UART_CMD_ECHO_EN
            if (tx_slot && echo_full) begin
                start_uart_tx <= 1'b1;
                uart_tx_data  <= echo_byte;
                echo_full     <= 1'b0;
            end
            if (uart_rx_ready && accepting) begin
                if (echo_full) rx_overrun <= 1'b1;
                else begin
                    echo_full <= 1'b1;
                    echo_byte <= uart_rx_data;
                end
            end
`endif
            case (state)
                IDLE: if (uart_rx_ready && !is_term && !is_space) begin
                    if (is_letter(uart_rx_data, CH_W) || is_letter(uart_rx_data, CH_R)) begin
                        state    <= ARGS;
                        op_write <= is_letter(uart_rx_data, CH_W);
                        acc      <= '0;
                        nib_cnt  <= '0;
                        line_len <= LW'(1);
                    end else state <= DISCARD;
                end
                ARGS: if (uart_rx_ready && !is_space) begin
                    if (is_term) begin
                        if (nib_cnt == (op_write ? LW'(4) : LW'(2))) begin
                            state    <= EXEC;
                            reg_addr <= op_write ? acc[15:8] : acc[7:0];
                            if (op_write) reg_wdata <= acc[7:0];
                            reg_we   <= op_write;
                            reg_re   <= !op_write;
                        end else begin
                            state <= RESP;
                            resp  <= {CH_E, CH_R, CR, LF};
                        end
                    end else if (is_hex && line_len < LW'(MAX_LINE)) begin
                        acc      <= {acc[11:0], nibble};
                        nib_cnt  <= nib_cnt + LW'(1);
                        line_len <= line_len + LW'(1);
                    end else state <= DISCARD;
                end
                EXEC: begin
                    state <= op_write ? RESP : READ_WAIT;
                    resp  <= {CH_O, CH_K, CR, LF};
                end
                READ_WAIT: begin
                    state <= RESP;
                    resp  <= {hex_hi, hex_lo, CR, LF};
                end
                DISCARD: if (uart_rx_ready && is_term) begin
                    state <= RESP;
                    resp  <= {CH_E, CH_R, CR, LF};
                end
                RESP: if (resp_slot) begin
                    start_uart_tx <= 1'b1;
                    uart_tx_data  <= resp[8*RESP_LEN-1 -: 8];
                    resp          <= resp << 8;
                    resp_idx      <= resp_idx + RESP_IW'(1);
                    if (resp_idx == RESP_IW'(RESP_LEN - 1)) begin
                        state    <= IDLE;
                        resp_idx <= '0;
                        nib_cnt  <= '0;
                        line_len <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed console sessions checked against a line-level model of the parser.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
    localparam int MAX_LINE = 8;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_ready = 1'b0;
    logic       uart_tx_fifo_ready = 1'b1;
    logic [7:0] reg_rdata = 8'h00;
    logic       start_uart_tx;
    logic [7:0] uart_tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic       rx_overrun;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txq[$];
    logic [17:0] opq[$];
    logic [7:0]  gotq[$];
    logic        exp_ovr = 1'b0;
    logic [7:0]  rd_val = 8'h00;
    bit          echo;

    uart_cmd_parser #(.MAX_LINE(MAX_LINE), .TERM_LF_ONLY(0)) dut (
        .clk               (clk),
        .reset             (reset),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_ready     (uart_rx_ready),
        .uart_tx_fifo_ready(uart_tx_fifo_ready),
        .start_uart_tx     (start_uart_tx),
        .uart_tx_data      (uart_tx_data),
        .reg_addr          (reg_addr),
        .reg_wdata         (reg_wdata),
        .reg_we            (reg_we),
        .reg_re            (reg_re),
        .reg_rdata         (reg_rdata),
        .rx_overrun        (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic string pick(input string with_echo, input string plain);
        return echo ? with_echo : plain;
    endfunction

    function automatic bit got_is(input string s);
        if (gotq.size() != s.len()) return 0;
        for (int i = 0; i < s.len(); i++) if (gotq[i] != s[i]) return 0;
        return 1;
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
    endtask

    // Runs on every negedge: register-bus responder plus all per-cycle output checks.
    task automatic monitor();
        int   cyc = 0;
        int   last = -100;
        logic prev_rdy = 1'b1;
        logic re_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            reg_rdata = re_prev ? rd_val : ~rd_val;
            re_prev = reg_re;
            cmp("rx_overrun", rx_overrun, exp_ovr);
            if (start_uart_tx) begin
                gotq.push_back(uart_tx_data);
                cmp("tx_gap", int'(cyc - last >= 2), 1);
                cmp("tx_ready", prev_rdy, 1);
                cmp("tx_expected", int'(txq.size() > 0), 1);
                if (txq.size() > 0) cmp("tx_data", uart_tx_data, txq.pop_front());
                last = cyc;
            end
            if (reg_we || reg_re) begin
                cmp("reg_op_expected", int'(opq.size() > 0), 1);
                if (opq.size() > 0)
                    cmp("reg_op", {reg_we, reg_re, reg_addr, reg_we ? reg_wdata : 8'h00}, opq.pop_front());
            end
            prev_rdy = uart_tx_fifo_ready;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        @(posedge clk);
        #1;
        uart_rx_data  = b;
        uart_rx_ready = 1'b1;
        if (stall) uart_tx_fifo_ready = 1'b0;
        @(posedge clk);
        #1;
        uart_rx_ready = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Line-level model: strip spaces, validate the whole line, then queue echo, bus op and reply.
    task automatic send_line(input string s, input logic [7:0] term, input bit stall);
        string c;
        string cu;
        string hx;
        int    a;
        int    d;
        bit    ok;
        c = "";
        for (int i = 0; i < s.len(); i++) if (s[i] != " ") c = {c, s.substr(i, i)};
        cu = c.toupper();
        if (echo) begin
            for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
            txq.push_back(term);
        end
        if (cu.len() > 0) begin
            ok = (cu[0] == "W" || cu[0] == "R") && cu.len() <= MAX_LINE;
            for (int i = 1; i < cu.len(); i++)
                if (!((cu[i] >= "0" && cu[i] <= "9") || (cu[i] >= "A" && cu[i] <= "F"))) ok = 0;
            if (ok && cu[0] == "W" && cu.len() == 5) begin
                void'($sscanf(cu.substr(1, 2), "%h", a));
                void'($sscanf(cu.substr(3, 4), "%h", d));
                opq.push_back({2'b10, a[7:0], d[7:0]});
                push_str("OK\015\012");
            end else if (ok && cu[0] == "R" && cu.len() == 3) begin
                void'($sscanf(cu.substr(1, 2), "%h", a));
                opq.push_back({2'b01, a[7:0], 8'h00});
                hx = $sformatf("%02x", rd_val);
                push_str({hx.toupper(), "\015\012"});
            end else push_str("ER\015\012");
        end
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
        send_byte(term, stall);
    endtask

    task automatic inject(input logic [7:0] b);
        @(posedge clk);
        #1;
        uart_rx_data  = b;
        uart_rx_ready = 1'b1;
        @(posedge clk);
        #1;
        uart_rx_ready = 1'b0;
        exp_ovr = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((txq.size() > 0 || opq.size() > 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        cmp("drain", txq.size() + opq.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_ovr = 1'b0;
        txq.delete();
        cmp("reset_outputs", {start_uart_tx, uart_tx_data, reg_addr, reg_wdata, reg_we, reg_re, rx_overrun}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        string bad[3];
        bad = '{"W12", "Q", "R123456789"};
`ifdef UART_CMD_ECHO_EN
        echo = 1'b1;
`else
        echo = 1'b0;
`endif
        do_reset();
        fork
            monitor();
        join_none

        gotq.delete();
        send_line("W3A5C", LF, 1'b0);
        drain();
        cmp("w_addr", reg_addr, 8'h3A);
        cmp("w_wdata", reg_wdata, 8'h5C);
        cmp("w_reply", got_is(pick("W3A5C\012OK\015\012", "OK\015\012")), 1);

        rd_val = 8'hB7;
        gotq.delete();
        send_line("r 3a", CR, 1'b0);
        drain();
        cmp("r_addr", reg_addr, 8'h3A);
        cmp("r_reply", got_is(pick("r 3a\015B7\015\012", "B7\015\012")), 1);
        gotq.delete();
        send_line("", LF, 1'b0);
        drain();
        cmp("empty_line", gotq.size(), int'(echo));

        foreach (bad[k]) begin
            gotq.delete();
            send_line(bad[k], LF, 1'b0);
            drain();
            cmp("bad_line", got_is(pick({bad[k], "\012ER\015\012"}, "ER\015\012")), 1);
        end
        cmp("bad_addr_kept", reg_addr, 8'h3A);

        gotq.delete();
        send_line("w 01 ff", LF, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        cmp("stall_quiet", gotq.size(), echo ? 7 : 0);
        cmp("stall_addr", reg_addr, 8'h01);
        cmp("stall_wdata", reg_wdata, 8'hFF);
        uart_tx_fifo_ready = 1'b1;
        drain();
        cmp("stall_reply", got_is(pick("w 01 ff\012OK\015\012", "OK\015\012")), 1);

        rd_val = 8'h5A;
        gotq.delete();
        send_line("R10", LF, 1'b0);
        inject("X");
        drain();
        cmp("ovr_reply", got_is(pick("R10\0125A\015\012", "5A\015\012")), 1);
        cmp("ovr_flag", rx_overrun, 1);
        cmp("ovr_addr", reg_addr, 8'h10);

        gotq.delete();
        send_line("W0102", LF, 1'b1);
        repeat (5) @(posedge clk);
        do_reset();
        uart_tx_fifo_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        cmp("abandon_tx", gotq.size(), echo ? 5 : 0);
        cmp("abandon_addr", reg_addr, 8'h00);

        rd_val = 8'hC3;
        gotq.delete();
        send_line("R00", LF, 1'b0);
        drain();
        cmp("r00_reply", got_is(pick("R00\012C3\015\012", "C3\015\012")), 1);
        cmp("r00_addr", reg_addr, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
